// File: rtl/alu_pkg.sv
// Shared definitions for the ALU front-end: opcodes, widths, FSM states.
package alu_pkg;

    localparam int OPND_W = 4;
    localparam int RES_W  = 5;
    localparam int OP_W   = 3;

    localparam logic [OP_W-1:0] OP_ADD  = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB  = 3'b001;
    localparam logic [OP_W-1:0] OP_XOR  = 3'b010;
    localparam logic [OP_W-1:0] OP_AND  = 3'b011;
    localparam logic [OP_W-1:0] OP_OR   = 3'b100;
    localparam logic [OP_W-1:0] OP_INVT = 3'b101;
    localparam logic [OP_W-1:0] OP_IDLE = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic op_is_legal(input logic [OP_W-1:0] op);
        return (op <= OP_INVT);
    endfunction

endpackage

// File: rtl/alu_result_mux.sv
// Folds the per-operation ALU result buses into one 5-bit result plus flags.
module alu_result_mux
    import alu_pkg::*;
(
    input  logic [OP_W-1:0]   i_op,
    input  logic [RES_W-1:0]  i_add_result,
    input  logic [RES_W-1:0]  i_sub_result,
    input  logic [OPND_W-1:0] i_xor_result,
    input  logic [OPND_W-1:0] i_and_result,
    input  logic [OPND_W-1:0] i_or_result,
    input  logic [OPND_W-1:0] i_invt_result,
    output logic [RES_W-1:0]  o_result,
    output logic              o_zero,
    output logic              o_carry,
    output logic              o_err
);

    always_comb begin
        o_result = '0;
        o_carry  = 1'b0;
        o_err    = 1'b0;
        case (i_op)
            OP_ADD: begin
                o_result = i_add_result;
                o_carry  = i_add_result[RES_W-1];
            end
            OP_SUB: begin
                // Bit 4 of the modulo-32 difference is the borrow (a < b).
                o_result = i_sub_result;
                o_carry  = i_sub_result[RES_W-1];
            end
            OP_XOR:  o_result = {1'b0, i_xor_result};
            OP_AND:  o_result = {1'b0, i_and_result};
            OP_OR:   o_result = {1'b0, i_or_result};
            OP_INVT: o_result = {1'b0, i_invt_result};
            default: o_err    = 1'b1;
        endcase
        o_zero = (o_result == '0);
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequential front-end for the combinational 4-bit ALU: request in, registered
// operands out, merged result and flags back over a response handshake.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter logic [OP_W-1:0] IDLE_SEL = OP_IDLE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPND_W-1:0] in_a,
    input  logic [OPND_W-1:0] in_b,
    input  logic [OP_W-1:0]   in_op,
    output logic [OPND_W-1:0] alu_a,
    output logic [OPND_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_select,
    input  logic [RES_W-1:0]  add_result,
    input  logic [RES_W-1:0]  sub_result,
    input  logic [OPND_W-1:0] xor_result,
    input  logic [OPND_W-1:0] and_result,
    input  logic [OPND_W-1:0] or_result,
    input  logic [OPND_W-1:0] invt_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [RES_W-1:0]  out_result,
    output logic [OP_W-1:0]   out_op,
    output logic              out_zero,
    output logic              out_carry,
    output logic              out_err,
    output state_t            o_dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid never waits on ready, and the sender holds its payload
    // stable until that edge.

    state_t              r_state;
    state_t              w_next_state;
    logic                w_accept;
    logic                w_deliver;

    logic [OPND_W-1:0]   r_alu_a;
    logic [OPND_W-1:0]   r_alu_b;
    logic [OP_W-1:0]     r_alu_sel;
    logic [OP_W-1:0]     r_op;
    logic [RES_W-1:0]    r_result;
    logic [OP_W-1:0]     r_out_op;
    logic                r_zero;
    logic                r_carry;
    logic                r_err;

    logic [RES_W-1:0]    w_mux_result;
    logic                w_mux_zero;
    logic                w_mux_carry;
    logic                w_mux_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_deliver    = 1'b0;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = EXEC;
                end
            end
            EXEC: begin
                w_next_state = RESP;
            end
            RESP: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_deliver    = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    alu_result_mux u_result_mux (
        .i_op          (r_op),
        .i_add_result  (add_result),
        .i_sub_result  (sub_result),
        .i_xor_result  (xor_result),
        .i_and_result  (and_result),
        .i_or_result   (or_result),
        .i_invt_result (invt_result),
        .o_result      (w_mux_result),
        .o_zero        (w_mux_zero),
        .o_carry       (w_mux_carry),
        .o_err         (w_mux_err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_sel <= IDLE_SEL;
            r_op      <= '0;
            r_result  <= '0;
            r_out_op  <= '0;
            r_zero    <= 1'b0;
            r_carry   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_alu_a   <= in_a;
                r_alu_b   <= in_b;
                r_op      <= in_op;
                // Illegal opcodes keep the ALU quiet; the mux flags them as errors.
                r_alu_sel <= op_is_legal(in_op) ? in_op : IDLE_SEL;
            end
            if (r_state == EXEC) begin
                r_result <= w_mux_result;
                r_out_op <= r_op;
                r_zero   <= w_mux_zero;
                r_carry  <= w_mux_carry;
                r_err    <= w_mux_err;
            end
            if (w_deliver) begin
                r_alu_sel <= IDLE_SEL;
            end
        end
    end

    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign alu_select  = r_alu_sel;
    assign out_result  = r_result;
    assign out_op      = r_out_op;
    assign out_zero    = r_zero;
    assign out_carry   = r_carry;
    assign out_err     = r_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: vector table, hand-written corner sequences and
// randomized traffic against an arithmetic reference model.
module tb_alu_op_sequencer;
    import alu_pkg::*;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
        logic [4:0] res;
        logic       zero;
        logic       carry;
        logic       err;
    } vec_t;

    localparam int N_RAND = 60;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic [2:0] in_op;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_select;
    logic [4:0] add_result;
    logic [4:0] sub_result;
    logic [3:0] xor_result;
    logic [3:0] and_result;
    logic [3:0] or_result;
    logic [3:0] invt_result;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] out_result;
    logic [2:0] out_op;
    logic       out_zero;
    logic       out_carry;
    logic       out_err;
    state_t     dbg_state;

    int n_pass  = 0;
    int n_total = 0;
    logic [10:0] exp_q[$];
    logic [4:0]  r_junk;

    always #5 clk = ~clk;

    alu_op_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_op       (in_op),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_select  (alu_select),
        .add_result  (add_result),
        .sub_result  (sub_result),
        .xor_result  (xor_result),
        .and_result  (and_result),
        .or_result   (or_result),
        .invt_result (invt_result),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_op      (out_op),
        .out_zero    (out_zero),
        .out_carry   (out_carry),
        .out_err     (out_err),
        .o_dbg_state (dbg_state)
    );

    // Stand-in for the ALU: only the selected bus carries a real result, the
    // others carry changing garbage so a wrong mux choice shows up.
    always @(posedge clk) r_junk <= 5'($urandom);

    always_comb begin
        add_result  = r_junk;
        sub_result  = r_junk ^ 5'h15;
        xor_result  = r_junk[3:0];
        and_result  = ~r_junk[3:0];
        or_result   = r_junk[4:1];
        invt_result = r_junk[3:0] ^ 4'h9;
        case (alu_select)
            3'd0: add_result  = 5'(alu_a) + 5'(alu_b);
            3'd1: sub_result  = 5'(alu_a) - 5'(alu_b);
            3'd2: xor_result  = alu_a ^ alu_b;
            3'd3: and_result  = alu_a & alu_b;
            3'd4: or_result   = alu_a | alu_b;
            3'd5: invt_result = ~alu_a;
            default: ;
        endcase
    end

    // Reference: {op, err, carry, zero, result} from plain integer arithmetic.
    function automatic logic [10:0] ref_resp(input logic [3:0] a, input logic [3:0] b,
                                             input logic [2:0] op);
        int   ia = int'(a);
        int   ib = int'(b);
        int   r  = 0;
        logic err = 1'b0;
        logic cy;
        case (op)
            3'd0: r = ia + ib;
            3'd1: r = (ia - ib + 32) % 32;
            3'd2: r = ia ^ ib;
            3'd3: r = ia & ib;
            3'd4: r = ia | ib;
            3'd5: r = 15 - ia;
            default: err = 1'b1;
        endcase
        cy = (op <= 3'd1) && (r >= 16);
        return {op, err, cy, (r == 0), 5'(r)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " in_ready"}, in_ready, 1);
        chk({tag, " out_valid"}, out_valid, 0);
        chk({tag, " out_regs"}, {out_result, out_op, out_zero, out_carry, out_err}, 0);
        chk({tag, " alu_ab"}, {alu_a, alu_b}, 0);
        chk({tag, " alu_select"}, alu_select, 3'd7);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        logic [2:0] es;
        es = (v.op > 3'd5) ? 3'd7 : v.op;
        @(negedge clk);
        in_a = v.a; in_b = v.b; in_op = v.op; in_valid = 1'b1; out_ready = 1'b1;
        chk({tag, " in_ready_idle"}, in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, " exec_no_valid"}, out_valid, 0);
        chk({tag, " exec_sel"}, alu_select, es);
        chk({tag, " exec_ab"}, {alu_a, alu_b}, {v.a, v.b});
        @(negedge clk);
        chk({tag, " resp_valid"}, out_valid, 1);
        chk({tag, " resp_in_ready"}, in_ready, 0);
        chk({tag, " resp_data"}, {out_op, out_err, out_carry, out_zero, out_result},
            {v.op, v.err, v.carry, v.zero, v.res});
        @(negedge clk);
        chk({tag, " post_valid"}, out_valid, 0);
        chk({tag, " post_in_ready"}, in_ready, 1);
        chk({tag, " post_sel"}, alu_select, 3'd7);
    endtask

    initial begin
        vec_t        vecs[11];
        logic [10:0] snap;
        logic [10:0] e;
        int          launched;
        int          recv;
        logic        took;

        vecs[0]  = '{4'hA, 4'h3, 3'd0, 5'b01101, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{4'hA, 4'h3, 3'd1, 5'b00111, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{4'h3, 4'hA, 3'd1, 5'b11001, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{4'hA, 4'h5, 3'd3, 5'b00000, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{4'hA, 4'h0, 3'd5, 5'b00101, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{4'h5, 4'h9, 3'd6, 5'b00000, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{4'hF, 4'h1, 3'd0, 5'b10000, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{4'hC, 4'hA, 3'd2, 5'b00110, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{4'h4, 4'h1, 3'd4, 5'b00101, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{4'h7, 4'h7, 3'd7, 5'b00000, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{4'h5, 4'h5, 3'd1, 5'b00000, 1'b1, 1'b0, 1'b0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_op = '0;
        repeat (2) @(negedge clk);
        chk_reset_vals("reset_held");
        rst = 1'b0;
        @(negedge clk);
        chk_reset_vals("reset_released");

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Backpressure: response held for 5 cycles while a new request is offered.
        @(negedge clk);
        in_a = 4'h5; in_b = 4'h6; in_op = 3'd4; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        snap = {out_op, out_err, out_carry, out_zero, out_result};
        chk("bp_first_resp", snap, ref_resp(4'h5, 4'h6, 3'd4));
        for (int k = 0; k < 5; k++) begin
            in_a = 4'hF; in_b = 4'hF; in_op = 3'd2; in_valid = 1'b1;
            @(negedge clk);
            chk($sformatf("bp_hold%0d valid", k), out_valid, 1);
            chk($sformatf("bp_hold%0d in_ready", k), in_ready, 0);
            chk($sformatf("bp_hold%0d data", k),
                {out_op, out_err, out_carry, out_zero, out_result}, snap);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("bp_after valid", out_valid, 0);
        chk("bp_after in_ready", in_ready, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("bp_no_phantom%0d", k), out_valid, 0);
        end

        // Reset pulsed in EXEC aborts the operation at once.
        in_a = 4'h9; in_b = 4'h4; in_op = 3'd1; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("abort_in_exec", out_valid, 0);
        rst = 1'b1;
        #1;
        chk_reset_vals("abort_async");
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("abort_no_resp%0d", k), out_valid, 0);
        end
        run_vec('{4'h9, 4'h4, 3'd1, 5'b00101, 1'b0, 1'b0, 1'b0}, "after_abort");

        // Randomized traffic with random gaps and response stalls.
        launched = 0; recv = 0; took = 1'b0;
        for (int cyc = 0; cyc < 3000 && recv < N_RAND; cyc++) begin
            @(negedge clk);
            if (took) in_valid = 1'b0;
            if (!in_valid && launched < N_RAND && $urandom_range(0, 3) != 0) begin
                in_a = 4'($urandom); in_b = 4'($urandom);
                in_op = 3'($urandom_range(0, 7));
                in_valid = 1'b1;
                launched++;
            end
            took = in_valid && in_ready;
            if (took) exp_q.push_back(ref_resp(in_a, in_b, in_op));
            out_ready = ($urandom_range(0, 2) != 0);
            if (out_valid && out_ready) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 11'bx;
                chk($sformatf("rand_resp%0d", recv),
                    {out_op, out_err, out_carry, out_zero, out_result}, e);
                recv++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("rand_all_received", recv, N_RAND);
        chk("rand_queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
